// File: rtl/alu_mc_if.sv
// Handshake/operand bundle for the multi-cycle ALU.
// The master drives operations and consumes results; the slave is the ALU.
interface alu_mc_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [2:0]       flag;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, out, flag
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, out, flag
    );
endinterface

// File: rtl/alu_mc.sv
// WIDTH-bit multi-cycle ALU: single-cycle arithmetic/logic/shift ops, iterative
// shift-add MUL, valid/ready on both sides and a {Z,V,N} flag register.
module alu_mc #(
    parameter int  WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     rst_n,
    alu_mc_if.slave bus
);
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_XOR = 3'b010,
        OP_AND = 3'b011,
        OP_SLL = 3'b100,
        OP_SRA = 3'b101,
        OP_ROR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_e           state, state_nxt;
    op_e              op_in, op_q;
    logic             idle, accept;
    logic [SHW-1:0]   shamt, cnt;
    logic [WIDTH-1:0] sum, diff, res;
    logic [2*WIDTH-1:0] rot;
    logic             ovf, ovf_q;
    logic [WIDTH-1:0] out_q, acc, acc_nxt, mcand, mplier;
    logic [2:0]       flag_q;

    assign op_in  = op_e'(bus.op);
    assign shamt  = bus.b[SHW-1:0];
    assign idle   = (state == IDLE);
    assign accept = bus.in_valid && idle;

    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;
    assign rot  = {bus.a, bus.a} >> shamt;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        unique case (op_in)
            OP_ADD: begin
                res = sum;
                ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_XOR: res = bus.a ^ bus.b;
            OP_AND: res = bus.a & bus.b;
            OP_SLL: res = bus.a << shamt;
            OP_SRA: res = $signed(bus.a) >>> shamt;
            OP_ROR: res = rot[WIDTH-1:0];
            OP_MUL: res = '0;
        endcase
    end

    // One multiplier bit per BUSY cycle, LSB first.
    assign acc_nxt = mplier[cnt] ? (acc + mcand) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = (op_in == OP_MUL) ? BUSY : DONE;
            BUSY: if (cnt == CNT_LAST) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_ADD;
            ovf_q  <= 1'b0;
            out_q  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            flag_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op_in;
                        ovf_q <= ovf;
                        if (op_in == OP_MUL) begin
                            mcand  <= bus.a;
                            mplier <= bus.b;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            out_q <= res;
                        end
                    end
                end
                BUSY: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    if (cnt == CNT_LAST) begin
                        out_q <= acc_nxt;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Flags commit only on the output handshake; N/V belong to ADD/SUB.
                    if (bus.out_ready) begin
                        flag_q[2] <= (out_q == '0);
                        if (op_q == OP_ADD || op_q == OP_SUB) begin
                            flag_q[1] <= ovf_q;
                            flag_q[0] <= out_q[WIDTH-1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = idle;
    assign bus.out_valid = (state == DONE);
    assign bus.out       = out_q;
    assign bus.flag      = flag_q;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=16 and WIDTH=8: drivers push expected
// results from an arithmetic reference model, a negedge monitor pops and compares.
module tb_alu_mc;
    localparam int W16 = 16;
    localparam int W8  = 8;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2, AND = 3'd3,
                           SLL = 3'd4, SRA = 3'd5, ROR = 3'd6, MUL = 3'd7;

    logic clk = 1'b0;
    logic rst_n, rst8_n;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W16)) bus ();
    alu_mc_if #(.WIDTH(W8))  bus8 ();

    alu_mc #(.WIDTH(W16)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
    alu_mc #(.WIDTH(W8))  dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));

    typedef struct {
        logic [63:0] res;
        logic [2:0]  fb;
        logic [2:0]  fa;
        int          acc_cyc;
        int          lat;
        bit          seen;
    } exp_t;

    exp_t       q16[$];
    exp_t       q8[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         hold16 = 0;
    logic [2:0] mf16 = '0, mf8 = '0, pf16 = '0, pf8 = '0;
    bit         pend16 = 0, pend8 = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Reference: signed values and overflow from plain integer arithmetic.
    function automatic logic [63:0] model(input int w, input logic [2:0] op,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] fin, output logic [2:0] fout);
        logic [63:0] mask, r;
        longint      sa, sb, s, lim;
        int          sh;
        bit          arith;
        mask  = (64'd1 << w) - 64'd1;
        lim   = longint'(1) << (w - 1);
        sa    = a[w-1] ? longint'(a) - 2 * lim : longint'(a);
        sb    = b[w-1] ? longint'(b) - 2 * lim : longint'(b);
        sh    = int'(b[15:0]) % w;
        s     = 0;
        arith = 0;
        case (op)
            ADD:     begin s = sa + sb; r = (a + b) & mask; arith = 1; end
            SUB:     begin s = sa - sb; r = (a - b) & mask; arith = 1; end
            XOR:     r = (a ^ b) & mask;
            AND:     r = (a & b) & mask;
            SLL:     r = (a << sh) & mask;
            SRA:     r = 64'(sa >>> sh) & mask;
            ROR:     r = ((a >> sh) | (a << (w - sh))) & mask;
            default: r = (a * b) & mask;
        endcase
        fout    = fin;
        fout[2] = (r == 64'd0);
        if (arith) begin
            fout[1] = (s >= lim) || (s < -lim);
            fout[0] = r[w-1];
        end
        return r;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- WIDTH=16 driver ----------------
    task automatic junk16();
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.op       = 3'($urandom);
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
    endtask

    task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int         n;
        exp_t       e;
        logic [2:0] fnew;
        n = 0;
        @(posedge clk); #1;
        while (!bus.in_ready) begin
            junk16();
            n++;
            if (n > 200) begin
                $display("FAIL issue16_timeout: in_ready stuck at 0, expected 1");
                $fatal(1);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        e.res     = model(W16, op, 64'(a), 64'(b), mf16, fnew);
        e.fb      = mf16;
        e.fa      = fnew;
        e.acc_cyc = cyc;
        e.lat     = (op == MUL) ? W16 + 1 : 1;
        e.seen    = 0;
        mf16      = fnew;
        q16.push_back(e);
    endtask

    task automatic idle16();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drive16();
        issue16(ADD, 16'h7FFF, 16'h0001);
        issue16(SUB, 16'h1234, 16'h1234);
        issue16(XOR, 16'h00F0, 16'h000F);
        issue16(ROR, 16'h8001, 16'd1);
        issue16(SRA, 16'h8000, 16'd15);
        issue16(SLL, 16'h0001, 16'd0);
        issue16(MUL, 16'h0003, 16'hFFFF);
        hold16 = 5;
        issue16(ADD, 16'h8000, 16'h8000);
        // Asynchronous reset in BUSY cycle 6 of a MUL, between clock edges.
        issue16(MUL, 16'h1234, 16'h5678);
        repeat (6) begin
            @(posedge clk); #1;
            junk16();
        end
        #2;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        q16.delete();
        mf16 = '0;
        pend16 = 0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue16(ADD, 16'h0002, 16'h0003);
        for (int i = 0; i < 150; i++) begin
            logic [15:0] a, b;
            if ($urandom_range(0, 4) == 0) idle16();
            a = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 16'h7FFF : 16'($urandom);
            issue16(3'($urandom), a, b);
        end
        idle16();
    endtask

    // ---------------- WIDTH=8 driver ----------------
    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int         n;
        exp_t       e;
        logic [2:0] fnew;
        n = 0;
        @(posedge clk); #1;
        while (!bus8.in_ready) begin
            bus8.in_valid = 1'($urandom_range(0, 1));
            bus8.op       = 3'($urandom);
            bus8.a        = 8'($urandom);
            bus8.b        = 8'($urandom);
            n++;
            if (n > 200) begin
                $display("FAIL issue8_timeout: in_ready stuck at 0, expected 1");
                $fatal(1);
            end
            @(posedge clk); #1;
        end
        bus8.in_valid = 1'b1;
        bus8.op = op;
        bus8.a  = a;
        bus8.b  = b;
        e.res     = model(W8, op, 64'(a), 64'(b), mf8, fnew);
        e.fb      = mf8;
        e.fa      = fnew;
        e.acc_cyc = cyc;
        e.lat     = (op == MUL) ? W8 + 1 : 1;
        e.seen    = 0;
        mf8       = fnew;
        q8.push_back(e);
    endtask

    task automatic drive8();
        issue8(MUL, 8'h0F, 8'h11);
        issue8(SUB, 8'h80, 8'h01);
        issue8(SRA, 8'h80, 8'd7);
        issue8(ROR, 8'h01, 8'd3);
        for (int i = 0; i < 60; i++) issue8(3'($urandom), 8'($urandom), 8'($urandom));
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
    endtask

    // Output consumers: random backpressure, plus a forced stall window on W16.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hold16 > 0) begin
                bus.out_ready = 1'b0;
                if (bus.out_valid) hold16--;
            end else begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        bus8.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus8.out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- Monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst16_out", 64'(bus.out), 64'd0);
            chk("rst16_flag", 64'(bus.flag), 64'd0);
            chk("rst16_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst16_in_ready", 64'(bus.in_ready), 64'd1);
            pend16 = 0;
        end else begin
            chk("in_ready16", 64'(bus.in_ready), 64'(!(q16.size() > 0 && cyc > q16[0].acc_cyc)));
            if (pend16) begin
                chk("flag16_after", 64'(bus.flag), 64'(pf16));
                pend16 = 0;
            end
            if (bus.out_valid) begin
                if (q16.size() == 0) begin
                    chk("out_valid16_unexpected", 64'(bus.out_valid), 64'd0);
                end else begin
                    if (!q16[0].seen) begin
                        chk("latency16", 64'(cyc - q16[0].acc_cyc), 64'(q16[0].lat));
                        q16[0].seen = 1;
                    end
                    chk("out16", 64'(bus.out), q16[0].res);
                    chk("flag16_hold", 64'(bus.flag), 64'(q16[0].fb));
                    if (bus.out_ready) begin
                        pf16 = q16[0].fa;
                        pend16 = 1;
                        void'(q16.pop_front());
                    end
                end
            end
        end

        if (!rst8_n) begin
            chk("rst8_out", 64'(bus8.out), 64'd0);
            chk("rst8_in_ready", 64'(bus8.in_ready), 64'd1);
            pend8 = 0;
        end else begin
            chk("in_ready8", 64'(bus8.in_ready), 64'(!(q8.size() > 0 && cyc > q8[0].acc_cyc)));
            if (pend8) begin
                chk("flag8_after", 64'(bus8.flag), 64'(pf8));
                pend8 = 0;
            end
            if (bus8.out_valid) begin
                if (q8.size() == 0) begin
                    chk("out_valid8_unexpected", 64'(bus8.out_valid), 64'd0);
                end else begin
                    if (!q8[0].seen) begin
                        chk("latency8", 64'(cyc - q8[0].acc_cyc), 64'(q8[0].lat));
                        q8[0].seen = 1;
                    end
                    chk("out8", 64'(bus8.out), q8[0].res);
                    chk("flag8_hold", 64'(bus8.flag), 64'(q8[0].fb));
                    if (bus8.out_ready) begin
                        pf8 = q8[0].fa;
                        pend8 = 1;
                        void'(q8.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        rst8_n = 1'b0;
        bus.in_valid  = 1'b0; bus.op  = '0; bus.a  = '0; bus.b  = '0;
        bus8.in_valid = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        rst8_n = 1'b1;
        fork
            drive16();
            drive8();
        join
        n = 0;
        while ((q16.size() != 0 || q8.size() != 0 || pend16 || pend8) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            $display("FAIL drain: %0d/%0d results still outstanding, expected 0", q16.size(), q8.size());
            $fatal(1);
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
